// File: rtl/pic_pkg.sv
// Shared constants for the PIC bus interface: INTA sequencer encoding,
// default CALL opcode and INTA pulse index values.
package pic_pkg;

   typedef enum logic [1:0] {
      INTA_IDLE = 2'd0,
      INTA_P1   = 2'd1,
      INTA_P2   = 2'd2,
      INTA_P3   = 2'd3
   } inta_state_t;

   localparam logic [7:0] CALL_OPCODE_DEFAULT = 8'hCD;

   localparam logic [1:0] INTA_IDX_NONE = 2'd0;
   localparam logic [1:0] INTA_IDX_1    = 2'd1;
   localparam logic [1:0] INTA_IDX_2    = 2'd2;
   localparam logic [1:0] INTA_IDX_3    = 2'd3;

endpackage

// File: rtl/pic_strobe_edge.sv
// Registers one active-low bus strobe and flags its falling and rising edges.
module pic_strobe_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic strobe_n,
   output logic fall,
   output logic rise
);

   logic strobe_q;

   always_ff @(posedge clk) begin
      if (!rst_n) strobe_q <= 1'b1;
      else        strobe_q <= strobe_n;
   end

   assign fall = strobe_q & ~strobe_n;
   assign rise = ~strobe_q & strobe_n;

endmodule

// File: rtl/pic_bus_interface.sv
// 8259-style PIC bus interface: register reads/writes and the INTA vector sequence.
// Optional poll command support is enabled with `define PIC_POLL_EN.
//
// state     | meaning
// INTA_IDLE | no acknowledge in progress, bus reads/writes allowed
// INTA_P1   | first INTA pulse seen (8080: CALL opcode, 8086: no drive)
// INTA_P2   | second pulse, vector_lo; 8086 sequence ends on its rising edge
// INTA_P3   | third pulse (8080 only), vector_hi; sequence ends on its rising edge
module pic_bus_interface
   import pic_pkg::*;
#(
   parameter int         DATA_WIDTH  = 8,
   parameter logic [7:0] CALL_OPCODE = CALL_OPCODE_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cs_n,
   input  logic                  rd_n,
   input  logic                  wr_n,
   input  logic                  a0,
   input  logic                  inta_n,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_oe,
   output logic                  buf_en_n,
   output logic                  wr_pulse,
   output logic                  wr_a0,
   output logic [DATA_WIDTH-1:0] wr_data,
   input  logic [DATA_WIDTH-1:0] imr,
   input  logic [DATA_WIDTH-1:0] irr,
   input  logic [DATA_WIDTH-1:0] isr,
   input  logic                  read_reg_en,
   input  logic                  read_isr_sel,
   input  logic                  mode_8086,
   input  logic                  vector_drive,
   input  logic [DATA_WIDTH-1:0] vector_lo,
   input  logic [DATA_WIDTH-1:0] vector_hi,
   output logic                  inta_edge,
   output logic [1:0]            inta_index,
   output logic                  inta_done,
   input  logic                  poll_cmd,
   input  logic [DATA_WIDTH-1:0] poll_word,
   output logic                  poll_ack
);

   logic rd_fall, rd_rise, wr_fall, wr_rise, inta_fall, inta_rise;
   logic cs_q, mode_q, mode_eff, poll_pend, done_next;
   inta_state_t state, state_next;
   logic [1:0] index_next;
   logic vec_valid, drive_vec, read_active, read_valid;
   logic [DATA_WIDTH-1:0] vec_byte, read_byte;

   pic_strobe_edge u_rd_edge   (.clk(clk), .rst_n(rst_n), .strobe_n(rd_n),   .fall(rd_fall),   .rise(rd_rise));
   pic_strobe_edge u_wr_edge   (.clk(clk), .rst_n(rst_n), .strobe_n(wr_n),   .fall(wr_fall),   .rise(wr_rise));
   pic_strobe_edge u_inta_edge (.clk(clk), .rst_n(rst_n), .strobe_n(inta_n), .fall(inta_fall), .rise(inta_rise));

   logic unused_edges;
   assign unused_edges = rd_fall ^ wr_fall;

   // The mode used for P1 is the live input on entry, then the latched copy.
   assign mode_eff = (state == INTA_IDLE) ? mode_8086 : mode_q;

   always_comb begin
      state_next = state;
      done_next  = 1'b0;
      case (state)
         INTA_IDLE: if (inta_fall) state_next = INTA_P1;
         INTA_P1:   if (inta_fall) state_next = INTA_P2;
         INTA_P2: begin
            if (inta_fall && !mode_q) begin
               state_next = INTA_P3;
            end else if (inta_rise && mode_q) begin
               state_next = INTA_IDLE;
               done_next  = 1'b1;
            end
         end
         INTA_P3: begin
            if (inta_rise) begin
               state_next = INTA_IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = INTA_IDLE;
      endcase
   end

   always_comb begin
      index_next = INTA_IDX_NONE;
      vec_valid  = 1'b0;
      vec_byte   = '0;
      case (state_next)
         INTA_P1: begin
            index_next = INTA_IDX_1;
            vec_valid  = !mode_eff;
            vec_byte   = DATA_WIDTH'(CALL_OPCODE);
         end
         INTA_P2: begin
            index_next = INTA_IDX_2;
            vec_valid  = 1'b1;
            vec_byte   = vector_lo;
         end
         INTA_P3: begin
            index_next = INTA_IDX_3;
            vec_valid  = 1'b1;
            vec_byte   = vector_hi;
         end
         default: ;
      endcase
   end

   assign drive_vec = ~inta_n & vector_drive & vec_valid;

   // A low inta_n in IDLE is the start of an acknowledge, so it blocks reads too.
   assign read_active = ~cs_n & ~rd_n & inta_n & (state == INTA_IDLE);

   always_comb begin
      read_valid = 1'b1;
      read_byte  = '0;
      if (poll_pend)        read_byte = poll_word;
      else if (a0)          read_byte = imr;
      else if (read_reg_en) read_byte = read_isr_sel ? isr : irr;
      else                  read_valid = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= INTA_IDLE;
         mode_q     <= 1'b0;
         cs_q       <= 1'b1;
         data_out   <= '0;
         data_oe    <= 1'b0;
         wr_pulse   <= 1'b0;
         wr_a0      <= 1'b0;
         wr_data    <= '0;
         inta_edge  <= 1'b0;
         inta_index <= INTA_IDX_NONE;
         inta_done  <= 1'b0;
      end else begin
         state     <= state_next;
         cs_q      <= cs_n;
         inta_edge <= inta_fall;
         inta_done <= done_next;
         if (state == INTA_IDLE && inta_fall) mode_q <= mode_8086;
         if (inta_fall) inta_index <= index_next;
         if (!cs_n && !wr_n) begin
            wr_a0   <= a0;
            wr_data <= data_in;
         end
         wr_pulse <= wr_rise & ~cs_q & (state == INTA_IDLE);
         if (drive_vec) begin
            data_out <= vec_byte;
            data_oe  <= 1'b1;
         end else if (read_active && read_valid) begin
            data_out <= read_byte;
            data_oe  <= 1'b1;
         end else begin
            data_oe  <= 1'b0;
         end
      end
   end

   assign buf_en_n = ~data_oe;

`ifdef PIC_POLL_EN
   logic poll_hit;
   assign poll_hit = rd_rise & poll_pend & ~cs_q & (state == INTA_IDLE);

   // A poll command landing on the acknowledging edge re-arms the flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         poll_pend <= 1'b0;
         poll_ack  <= 1'b0;
      end else begin
         poll_pend <= poll_cmd | (poll_pend & ~poll_hit);
         poll_ack  <= poll_hit;
      end
   end
`else
   logic unused_poll;
   assign unused_poll = poll_cmd ^ rd_rise;
   assign poll_pend   = 1'b0;
   assign poll_ack    = 1'b0;
`endif

endmodule

// File: tb/tb_pic_bus_interface.sv
// Directed bench for pic_bus_interface: writes, reads, 8086/8080 INTA, reset abort, poll.
module tb_pic_bus_interface;

   logic       clk = 1'b0;
   logic       rst_n, cs_n, rd_n, wr_n, a0, inta_n;
   logic [7:0] data_in, data_out, wr_data, imr, irr, isr, vector_lo, vector_hi, poll_word;
   logic       data_oe, buf_en_n, wr_pulse, wr_a0, read_reg_en, read_isr_sel;
   logic       mode_8086, vector_drive, inta_edge, inta_done, poll_cmd, poll_ack;
   logic [1:0] inta_index;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pic_bus_interface dut (
      .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0),
      .inta_n(inta_n), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
      .buf_en_n(buf_en_n), .wr_pulse(wr_pulse), .wr_a0(wr_a0), .wr_data(wr_data),
      .imr(imr), .irr(irr), .isr(isr), .read_reg_en(read_reg_en),
      .read_isr_sel(read_isr_sel), .mode_8086(mode_8086), .vector_drive(vector_drive),
      .vector_lo(vector_lo), .vector_hi(vector_hi), .inta_edge(inta_edge),
      .inta_index(inta_index), .inta_done(inta_done), .poll_cmd(poll_cmd),
      .poll_word(poll_word), .poll_ack(poll_ack)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One INTA low/high pulse; checks the edge pulse, index, drive and done.
   task automatic inta_pulse(input string tag, input logic [1:0] idx, input logic exp_oe,
                             input logic [7:0] exp_data, input logic exp_done);
      inta_n = 1'b0;
      tick();
      check({tag, "_edge"}, inta_edge, 1);
      check({tag, "_index"}, inta_index, idx);
      check({tag, "_oe"}, data_oe, exp_oe);
      check({tag, "_buf_en_n"}, buf_en_n, !exp_oe);
      if (exp_oe) check({tag, "_data"}, data_out, exp_data);
      inta_n = 1'b1;
      tick();
      check({tag, "_edge_clr"}, inta_edge, 0);
      check({tag, "_done"}, inta_done, exp_done);
      check({tag, "_oe_off"}, data_oe, 0);
   endtask

   task automatic do_read(input string tag, input logic addr, input logic exp_oe,
                          input logic [7:0] exp_data);
      cs_n = 1'b0; a0 = addr; rd_n = 1'b0;
      tick();
      check({tag, "_oe"}, data_oe, exp_oe);
      check({tag, "_buf_en_n"}, buf_en_n, !exp_oe);
      if (exp_oe) check({tag, "_data"}, data_out, exp_data);
      rd_n = 1'b1;
      tick();
      cs_n = 1'b1;
      check({tag, "_oe_off"}, data_oe, 0);
   endtask

   initial begin
      rst_n = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; inta_n = 1'b1;
      data_in = 8'h00; imr = 8'h3C; irr = 8'hC3; isr = 8'h5A;
      read_reg_en = 1'b0; read_isr_sel = 1'b0; mode_8086 = 1'b1; vector_drive = 1'b1;
      vector_lo = 8'h4B; vector_hi = 8'h77; poll_cmd = 1'b0; poll_word = 8'h83;
      tick(); tick();
      check("rst_data_out", data_out, 0);
      check("rst_data_oe", data_oe, 0);
      check("rst_buf_en_n", buf_en_n, 1);
      check("rst_wr_pulse", wr_pulse, 0);
      check("rst_wr_a0", wr_a0, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_inta_index", inta_index, 0);
      check("rst_inta_done", inta_done, 0);
      check("rst_poll_ack", poll_ack, 0);
      rst_n = 1'b1;
      tick();

      // write: three low cycles, one pulse on the release
      cs_n = 1'b0; a0 = 1'b1; data_in = 8'hA5; wr_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("wr_no_pulse_low", wr_pulse, 0);
      end
      wr_n = 1'b1;
      tick();
      check("wr_pulse", wr_pulse, 1);
      check("wr_a0", wr_a0, 1);
      check("wr_data", wr_data, 8'hA5);
      cs_n = 1'b1;
      tick();
      check("wr_pulse_once", wr_pulse, 0);

      // reads
      do_read("rd_imr", 1'b1, 1'b1, 8'h3C);
      read_reg_en = 1'b1; read_isr_sel = 1'b1;
      do_read("rd_isr", 1'b0, 1'b1, 8'h5A);
      read_isr_sel = 1'b0;
      do_read("rd_irr", 1'b0, 1'b1, 8'hC3);
      read_reg_en = 1'b0;
      do_read("rd_none", 1'b0, 1'b0, 8'h00);

      // 8086 acknowledge, with a blocked read and write in the middle
      mode_8086 = 1'b1; vector_lo = 8'h4B;
      inta_pulse("i86_p1", 2'd1, 1'b0, 8'h00, 1'b0);
      mode_8086 = 1'b0;
      do_read("i86_rd_blocked", 1'b1, 1'b0, 8'h00);
      cs_n = 1'b0; wr_n = 1'b0; tick(); wr_n = 1'b1; tick();
      check("i86_wr_blocked", wr_pulse, 0);
      cs_n = 1'b1;
      inta_pulse("i86_p2", 2'd2, 1'b1, 8'h4B, 1'b1);
      tick();
      check("i86_done_once", inta_done, 0);

      // 8080 acknowledge, then again with the vector not driven
      mode_8086 = 1'b0; vector_lo = 8'h20; vector_hi = 8'h01;
      inta_pulse("i80_p1", 2'd1, 1'b1, 8'hCD, 1'b0);
      inta_pulse("i80_p2", 2'd2, 1'b1, 8'h20, 1'b0);
      inta_pulse("i80_p3", 2'd3, 1'b1, 8'h01, 1'b1);
      vector_drive = 1'b0;
      inta_pulse("i80nd_p1", 2'd1, 1'b0, 8'h00, 1'b0);
      inta_pulse("i80nd_p2", 2'd2, 1'b0, 8'h00, 1'b0);
      inta_pulse("i80nd_p3", 2'd3, 1'b0, 8'h00, 1'b1);
      vector_drive = 1'b1;

      // reset in the middle of an acknowledge
      inta_pulse("abort_p1", 2'd1, 1'b1, 8'hCD, 1'b0);
      rst_n = 1'b0;
      tick();
      check("abort_index", inta_index, 0);
      check("abort_edge", inta_edge, 0);
      check("abort_done", inta_done, 0);
      check("abort_oe", data_oe, 0);
      check("abort_wr_data", wr_data, 0);
      rst_n = 1'b1;
      tick();
      check("abort_no_done", inta_done, 0);
      inta_pulse("restart_p1", 2'd1, 1'b1, 8'hCD, 1'b0);
      inta_pulse("restart_p2", 2'd2, 1'b1, 8'h20, 1'b0);
      inta_pulse("restart_p3", 2'd3, 1'b1, 8'h01, 1'b1);

      // poll command
      poll_cmd = 1'b1; tick(); poll_cmd = 1'b0;
`ifdef PIC_POLL_EN
      cs_n = 1'b0; a0 = 1'b0; rd_n = 1'b0;
      tick();
      check("poll_data", data_out, 8'h83);
      check("poll_oe", data_oe, 1);
      rd_n = 1'b1;
      tick();
      check("poll_ack", poll_ack, 1);
      cs_n = 1'b1;
      tick();
      check("poll_ack_once", poll_ack, 0);
      do_read("poll_after", 1'b1, 1'b1, 8'h3C);
`else
      do_read("nopoll_rd", 1'b1, 1'b1, 8'h3C);
      check("nopoll_ack", poll_ack, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pic_bus_interface.md
PIC_BUS_INTERFACE -- requirements
Module: pic_bus_interface

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the bus width and the width of the IMR/IRR/ISR registers and vector bytes (legal 8 or 16).
REQ-002 SHALL have parameter CALL_OPCODE, default 8'hCD, meaning the first byte driven in an 8080-mode INTA sequence (zero-extended to DATA_WIDTH).
REQ-003 SHALL have ports: clk in 1 system clock; rst_n in 1 reset, synchronous, active-low; one clock domain only.
REQ-004 SHALL have ports: cs_n in 1 chip select; rd_n in 1 read strobe; wr_n in 1 write strobe; a0 in 1 address bit; inta_n in 1 interrupt acknowledge.
REQ-005 SHALL have ports: data_in in DATA_WIDTH bus write data; data_out out DATA_WIDTH bus read data; data_oe out 1 bus driver enable; buf_en_n out 1 external transceiver enable (low while driving).
REQ-006 SHALL have ports: wr_pulse out 1 one-cycle write commit; wr_a0 out 1 and wr_data out DATA_WIDTH, the captured address and data.
REQ-007 SHALL have ports: imr, irr, isr in DATA_WIDTH each; read_reg_en in 1; read_isr_sel in 1 (1=ISR, 0=IRR).
REQ-008 SHALL have ports: mode_8086 in 1; vector_drive in 1 (this device supplies the vector); vector_lo, vector_hi in DATA_WIDTH each.
REQ-009 SHALL have ports: inta_edge out 1 one-cycle pulse per INTA falling edge; inta_index out 2 (pulse number 1..3); inta_done out 1 one-cycle pulse at sequence end.
REQ-010 SHALL have ports: poll_cmd in 1; poll_word in DATA_WIDTH; poll_ack out 1.

Function
REQ-011 SHALL register rd_n, wr_n, inta_n each cycle and detect edges by comparing current with registered values.
REQ-012 SHALL capture data_in and a0 on every cycle with cs_n=0 and wr_n=0, and on the wr_n rising edge (registered cs_n=0) assert wr_pulse for exactly one cycle with the last captured values.
REQ-013 SHALL, while cs_n=0, rd_n=0, INTA FSM idle, update data_out one cycle later: a0=1 -> imr; a0=0, read_reg_en=1 -> isr or irr per read_isr_sel; otherwise data_oe=0.
REQ-014 SHALL implement INTA FSM states IDLE, P1, P2, P3; each inta_n falling edge advances one state and pulses inta_edge with inta_index=1,2,3.
REQ-015 SHALL, in 8086 mode (mode_8086 sampled at entry to P1, held until IDLE): P1 drive nothing; P2 drive vector_lo; inta_done on P2's inta_n rising edge, then IDLE.
REQ-016 SHALL, in 8080 mode: P1 drive CALL_OPCODE; P2 drive vector_lo; P3 drive vector_hi; inta_done on P3's inta_n rising edge, then IDLE.
REQ-017 SHALL drive vector bytes only while inta_n=0 and vector_drive=1, one cycle after the falling edge; data_oe=0 otherwise.
REQ-018 SHALL give INTA priority over reads: rd_n=0 during any non-IDLE state produces no register read.
REQ-019 SHALL assert buf_en_n=0 exactly when data_oe=1.
REQ-020 SHALL ignore wr_n activity during non-IDLE states (no wr_pulse).

Reset
REQ-021 SHALL, on clk edge with rst_n=0: data_out=0, data_oe=0, buf_en_n=1, wr_pulse=0, wr_a0=0, wr_data=0, inta_edge=0, inta_index=0, inta_done=0, poll_ack=0, FSM=IDLE, edge registers=1.
REQ-022 SHALL abort any INTA sequence on reset without emitting inta_done.

Configuration
REQ-023 SHALL, with PIC_POLL_EN defined, set a poll-pending flag on poll_cmd; next read (either a0) returns poll_word instead of registers, pulses poll_ack on rd_n rising edge, clears flag; poll_cmd coincident with that rising edge re-arms it.
REQ-024 SHALL, without PIC_POLL_EN, ignore poll_cmd and tie poll_ack to 0.

Structure
REQ-025 SHALL place FSM state encoding, default CALL_OPCODE value and INTA index constants in shared package pic_pkg.
REQ-026 SHALL isolate strobe registering and edge detection in sub-module pic_strobe_edge, instantiated once per strobe.

Verification
REQ-027 Write cs_n=0,a0=1,data_in=8'hA5, wr_n low 3 cycles then high -> one wr_pulse, wr_a0=1, wr_data=8'hA5.
REQ-028 Read a0=1, imr=8'h3C -> data_out=8'h3C, data_oe=1, buf_en_n=0 one cycle after rd_n fall.
REQ-029 8086 mode, vector_lo=8'h4B, two INTA pulses -> no drive on P1, 8'h4B on P2, inta_index 1,2, one inta_done.
REQ-030 8080 mode, vector_lo=8'h20, vector_hi=8'h01, three pulses -> 8'hCD, 8'h20, 8'h01; vector_drive=0 repeat -> data_oe stays 0.
REQ-031 rst_n=0 after first INTA pulse -> all outputs at reset values, no inta_done; next INTA starts at inta_index=1.
REQ-032 PIC_POLL_EN, poll_cmd then read, poll_word=8'h83 -> data_out=8'h83, one poll_ack; second read returns register.
